// File: rtl/updi_phy_target_if.sv
// Buffer-memory port of the UPDI target PHY (single-port SRAM style).
interface updi_phy_target_if #(
    parameter int ADDR_W = 7
);
    logic              csb0;
    logic              web0;
    logic [ADDR_W-1:0] addr0;
    logic [7:0]        wdata;
    logic [7:0]        rdata;

    modport master (output csb0, web0, addr0, wdata, input rdata);
    modport slave  (input csb0, web0, addr0, wdata, output rdata);
endinterface

// File: rtl/updi_phy_target.sv
// UPDI target PHY: 12-bit half-duplex UART responder with buffer memory.
// Optional break detection is enabled with `define PHY_BREAK_DETECT_EN.
module updi_phy_target #(
    parameter int CLKS_PER_BIT = 16,
    parameter int ADDR_W       = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              tx,
    output logic              tx_oe,
    updi_phy_target_if.master mem,
    input  logic              rsp_start,
    input  logic [ADDR_W-1:0] rsp_base,
    input  logic [ADDR_W-1:0] rsp_len,
    output logic [ADDR_W-1:0] rx_cnt,
    output logic              rx_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overflow,
    output logic              break_det,
    output logic              busy,
    output logic              tx_done
);
    localparam int CW = $clog2(2 * CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] GRD_M1  = CW'(2 * CLKS_PER_BIT - 1);

    typedef enum logic [3:0] {
        IDLE, RX_START, RX_BITS, RX_STORE, TX_GUARD,
        TX_FETCH, TX_LATCH, TX_BITS, TX_END, BRK_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        sync_q;
    logic              prev_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        bit_q, bit_d;
    logic [7:0]        rx_sh_q, rx_sh_d;
    logic              par_q, par_d, stp_q, stp_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rx_cnt_q, rx_cnt_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d, left_q, left_d;
    logic [11:0]       tx_sh_q, tx_sh_d;
    logic              more_q, more_d;
    logic              perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
    logic              rx_s, fall, par_bad, stp_bad, brk;

    assign rx_s = sync_q[1];
    assign fall = prev_q & ~rx_s;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            sync_q   <= 2'b11;
            prev_q   <= 1'b1;
            cnt_q    <= '0;
            bit_q    <= '0;
            rx_sh_q  <= '0;
            par_q    <= 1'b0;
            stp_q    <= 1'b0;
            wr_ptr_q <= '0;
            rx_cnt_q <= '0;
            rd_ptr_q <= '0;
            left_q   <= '0;
            tx_sh_q  <= '1;
            more_q   <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= {sync_q[0], rx};
            prev_q   <= rx_s;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            rx_sh_q  <= rx_sh_d;
            par_q    <= par_d;
            stp_q    <= stp_d;
            wr_ptr_q <= wr_ptr_d;
            rx_cnt_q <= rx_cnt_d;
            rd_ptr_q <= rd_ptr_d;
            left_q   <= left_d;
            tx_sh_q  <= tx_sh_d;
            more_q   <= more_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_d     = bit_q;
        rx_sh_d   = rx_sh_q;
        par_d     = par_q;
        stp_d     = stp_q;
        wr_ptr_d  = wr_ptr_q;
        rx_cnt_d  = rx_cnt_q;
        rd_ptr_d  = rd_ptr_q;
        left_d    = left_q;
        tx_sh_d   = tx_sh_q;
        more_d    = more_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        ovf_d     = ovf_q;
        mem.csb0  = 1'b1;
        mem.web0  = 1'b1;
        mem.addr0 = '0;
        mem.wdata = '0;
        rx_valid  = 1'b0;
        tx        = 1'b1;
        tx_oe     = 1'b0;
        tx_done   = 1'b0;
        break_det = 1'b0;
        par_bad   = ^{rx_sh_q, par_q};
        stp_bad   = ~(stp_q & rx_s);
        brk       = (rx_sh_q == 8'd0) & ~par_q & ~stp_q & ~rx_s;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (fall) begin
                    state_d = RX_START;
                end else if (rsp_start && rsp_len != '0) begin
                    state_d  = TX_GUARD;
                    rd_ptr_d = rsp_base;
                    left_d   = rsp_len;
                    more_d   = 1'b0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : RX_BITS;
                end
            end
            RX_BITS: begin
                if (cnt_q == BIT_M1) begin
                    cnt_d = '0;
                    bit_d = bit_q + 4'd1;
                    if (bit_q < 4'd8) begin
                        rx_sh_d = {rx_s, rx_sh_q[7:1]};
                    end else if (bit_q == 4'd8) begin
                        par_d = rx_s;
                    end else if (bit_q == 4'd9) begin
                        stp_d = rx_s;
                    end else begin
                        state_d = (par_bad | stp_bad) ? IDLE : RX_STORE;
                        perr_d  = perr_q | par_bad;
                        ferr_d  = ferr_q | stp_bad;
`ifdef PHY_BREAK_DETECT_EN
                        // An all-zero frame is a break, not a framing fault
                        if (brk) begin
                            state_d = BRK_WAIT;
                            ferr_d  = ferr_q;
                        end
`endif
                    end
                end
            end
            RX_STORE: begin
                mem.csb0  = 1'b0;
                mem.web0  = 1'b0;
                mem.addr0 = wr_ptr_q;
                mem.wdata = rx_sh_q;
                rx_valid  = 1'b1;
                wr_ptr_d  = wr_ptr_q + 1'b1;
                ovf_d     = ovf_q | (&wr_ptr_q);
                if (!(&rx_cnt_q)) rx_cnt_d = rx_cnt_q + 1'b1;
                state_d   = IDLE;
            end
            TX_GUARD: begin
                if (cnt_q == GRD_M1) state_d = TX_FETCH;
            end
            TX_FETCH: begin
                mem.csb0  = 1'b0;
                mem.addr0 = rd_ptr_q;
                tx_oe     = more_q;
                state_d   = TX_LATCH;
            end
            TX_LATCH: begin
                tx_oe   = more_q;
                tx_sh_d = {2'b11, ^mem.rdata, mem.rdata, 1'b0};
                cnt_d   = '0;
                bit_d   = '0;
                state_d = TX_BITS;
            end
            TX_BITS: begin
                tx_oe = 1'b1;
                tx    = tx_sh_q[0];
                if (cnt_q == BIT_M1) begin
                    cnt_d   = '0;
                    bit_d   = bit_q + 4'd1;
                    tx_sh_d = {1'b1, tx_sh_q[11:1]};
                    if (bit_q == 4'd11) begin
                        left_d   = left_q - 1'b1;
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        more_d   = 1'b1;
                        state_d  = (left_q == ADDR_W'(1)) ? TX_END : TX_FETCH;
                    end
                end
            end
            TX_END: begin
                tx_done = 1'b1;
                state_d = IDLE;
            end
            BRK_WAIT: begin
`ifdef PHY_BREAK_DETECT_EN
                if (rx_s) begin
                    break_det = 1'b1;
                    wr_ptr_d  = '0;
                    rx_cnt_d  = '0;
                    state_d   = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_cnt     = rx_cnt_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overflow   = ovf_q;
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_updi_phy_target.sv
// Self-checking bench for updi_phy_target: random frames and responses
// checked against a frame-level model of line, memory and status flags.
module tb_updi_phy_target;
    localparam int CPB = 16;
    localparam int AW  = 7;
    localparam int FR  = 12 * CPB;

    typedef struct {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx = 1'b1;
    logic          rsp_start = 1'b0;
    logic [AW-1:0] rsp_base = '0;
    logic [AW-1:0] rsp_len = '0;
    logic          tx, tx_oe, rx_valid, parity_err, frame_err;
    logic          overflow, break_det, busy, tx_done;
    logic [AW-1:0] rx_cnt;

    int n_vec = 0;
    int n_bad = 0;
    int n_done = 0;
    int n_brk = 0;

    logic [7:0]    m [128];
    logic [7:0]    mdl [128];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [7:0]    pl_data = '0;
    wr_t           wq [$];

    int  e_wp, e_cnt;
    bit  e_perr, e_ferr, e_ovf;

    updi_phy_target_if #(.ADDR_W(AW)) bus ();

    updi_phy_target #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .rx(rx), .tx(tx), .tx_oe(tx_oe),
        .mem(bus), .rsp_start(rsp_start), .rsp_base(rsp_base),
        .rsp_len(rsp_len), .rx_cnt(rx_cnt), .rx_valid(rx_valid),
        .parity_err(parity_err), .frame_err(frame_err),
        .overflow(overflow), .break_det(break_det), .busy(busy),
        .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (pl_en) m[pl_addr] <= pl_data;
        else if (!bus.csb0) begin
            if (!bus.web0) m[bus.addr0] <= bus.wdata;
            else bus.rdata <= m[bus.addr0];
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (rx_valid || (!bus.csb0 && !bus.web0)) begin
                chk("rx_valid_vs_write", rx_valid, !bus.csb0 && !bus.web0);
                if (!bus.csb0 && !bus.web0) wq.push_back('{bus.addr0, bus.wdata});
            end
            if (tx_done) n_done++;
            if (break_det) n_brk++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        wq.delete();
        e_wp = 0; e_cnt = 0;
        e_perr = 0; e_ferr = 0; e_ovf = 0;
    endtask

    task automatic preload(input int a, input logic [7:0] d);
        pl_addr = AW'(a);
        pl_data = d;
        pl_en = 1'b1;
        tick(1);
        pl_en = 1'b0;
        mdl[a] = d;
    endtask

    task automatic frame(input logic [7:0] d, input bit p, input bit s1,
                         input bit s2);
        logic [11:0] b;
        bit          good;
        wr_t         w;
        b = {s2, s1, p, d, 1'b0};
        for (int i = 0; i < 12; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = 1'b1;
        tick(2 * CPB);
        good = ((^d) == p) && s1 && s2;
        if ((^d) != p) e_perr = 1;
        if (!(s1 && s2)) e_ferr = 1;
        chk("write_count", wq.size(), good ? 1 : 0);
        if (good && wq.size() > 0) begin
            w = wq.pop_front();
            chk("write_addr", w.a, e_wp);
            chk("write_data", w.d, d);
            mdl[e_wp] = d;
            if (e_wp == 127) e_ovf = 1;
            e_wp = (e_wp + 1) % 128;
            if (e_cnt < 127) e_cnt++;
        end
        wq.delete();
        chk("rx_cnt", rx_cnt, e_cnt);
        chk("parity_err", parity_err, e_perr);
        chk("frame_err", frame_err, e_ferr);
        chk("overflow", overflow, e_ovf);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit good);
        frame(d, (^d) ^ !good, 1'b1, 1'b1);
    endtask

    function automatic bit fbit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (k == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic do_rsp(input int base, input int len);
        int  tend, u, j, r, d0;
        bit  eoe, etx, edone;
        d0 = n_done;
        rsp_base = AW'(base);
        rsp_len = AW'(len);
        rsp_start = 1'b1;
        tick(1);
        rsp_start = 1'b0;
        tend = 2 * CPB + len * (FR + 2);
        for (int t = 0; t <= tend + 2; t++) begin
            eoe = 0; etx = 1; edone = 0;
            if (t >= 2 * CPB + 2) begin
                u = t - (2 * CPB + 2);
                j = u / (FR + 2);
                r = u % (FR + 2);
                if (j < len) begin
                    if (r < FR) begin
                        eoe = 1;
                        etx = fbit(mdl[(base + j) % 128], r / CPB);
                    end else if (j < len - 1) begin
                        eoe = 1;
                    end else begin
                        edone = (r == FR);
                    end
                end
            end
            chk("tx_oe", tx_oe, eoe);
            if (eoe) chk("tx", tx, etx);
            chk("tx_done", tx_done, edone);
            tick(1);
        end
        chk("tx_done_count", n_done - d0, 1);
        chk("busy_after_rsp", busy, 0);
    endtask

    initial begin
        int b0;
        tick(3);
        chk("rst_tx", tx, 1);
        chk("rst_tx_oe", tx_oe, 0);
        chk("rst_csb0", bus.csb0, 1);
        chk("rst_web0", bus.web0, 1);
        chk("rst_addr0", bus.addr0, 0);
        chk("rst_wdata", bus.wdata, 0);
        chk("rst_rx_cnt", rx_cnt, 0);
        chk("rst_flags", {rx_valid, parity_err, frame_err, overflow}, 0);
        chk("rst_pulses", {break_det, busy, tx_done}, 0);
        do_reset();

        send_byte(8'hA5, 1'b1);

        do_reset();
        send_byte(8'h01, 1'b0);
        send_byte(8'h3C, 1'b1);

        rx = 1'b0;
        tick(4);
        chk("glitch_busy", busy, 1);
        rx = 1'b1;
        tick(CPB);
        chk("glitch_idle", busy, 0);
        chk("glitch_flags", {parity_err, frame_err}, 2'b10);
        chk("glitch_nowrite", wq.size(), 0);

        frame(8'h5A, ^8'h5A, 1'b1, 1'b0);

        rsp_len = '0;
        rsp_start = 1'b1;
        tick(1);
        rsp_start = 1'b0;
        tick(1);
        chk("len0_ignored", busy, 0);

        preload(5, 8'h55);
        preload(6, 8'h80);
        do_rsp(5, 2);

        for (int i = 0; i < 16; i++)
            send_byte(8'($urandom), $urandom_range(0, 3) != 0);

        preload(127, 8'($urandom));
        preload(0, 8'($urandom));
        do_rsp(127, 2);
        for (int i = 0; i < 2; i++) begin
            int bs, ln;
            bs = $urandom_range(0, 127);
            ln = $urandom_range(1, 3);
            for (int k = 0; k < ln; k++) preload((bs + k) % 128, 8'($urandom));
            do_rsp(bs, ln);
        end

        do_reset();
        for (int i = 0; i < 129; i++) send_byte(8'($urandom), 1'b1);
        chk("ovf_flag", overflow, 1);
        chk("ovf_cnt_sat", rx_cnt, 127);
        chk("ovf_wp", e_wp, 1);
        do_rsp(0, 1);

        b0 = n_brk;
        rx = 1'b0;
        tick(13 * CPB);
        rx = 1'b1;
        tick(2 * CPB);
`ifdef PHY_BREAK_DETECT_EN
        chk("brk_pulse", n_brk - b0, 1);
        chk("brk_cnt", rx_cnt, 0);
        chk("brk_no_ferr", frame_err, 0);
        e_wp = 0;
        e_cnt = 0;
`else
        chk("brk_pulse", n_brk - b0, 0);
        chk("brk_ferr", frame_err, 1);
        chk("brk_cnt", rx_cnt, 127);
        e_ferr = 1;
`endif
        chk("brk_nowrite", wq.size(), 0);
        send_byte(8'hC3, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
